pipeline_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage RV32I pipeline. It watches the register sources of the instruction in ID against the destinations in EX, MEM and WB, plus branch/jump resolution in EX. It drives the PC enable, the IF/ID enable and flush, the ID/EX bubble, and (optionally) the EX operand forwarding selects. It holds a small stall FSM with a cycle counter, so multi-cycle RAW stalls are sequenced rather than re-detected every cycle.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_match.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pipeline_hazard_pkg
// Description : Shared encodings for the RV32I hazard/stall controller:
//               stall FSM states, EX forwarding selects, and the
//               MemtoReg code that marks a load.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_pkg;

  // Stall FSM states
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;  // register file read value
  localparam logic [1:0] FWD_MEM = 2'b01;  // ALU result held in EX/MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // write-back data

  // MemtoReg encoding of a load instruction
  localparam logic [1:0] MEMTOREG_LOAD = 2'b01;

endpackage : pipeline_hazard_pkg
`default_nettype wire

// File: rtl/hazard_match.sv
`default_nettype none
// ============================================================================
// Module      : hazard_match
// Description : Compares one ID source register against one downstream
//               destination. Matches only when the source is actually read,
//               the stage writes the register file, and the destination is
//               not x0 (x0 writes are discarded, so never a dependency).
// Ports       : rs_addr   - source register address in ID
//               rs_used   - ID instruction reads this source
//               rd_addr   - destination register address of the stage
//               reg_write - stage writes the register file
//               match     - dependency exists
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              rs_used,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic              reg_write,
  output logic              match
);

  assign match = rs_used && reg_write && (rd_addr != '0) && (rd_addr == rs_addr);

endmodule : hazard_match
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard and stall controller for a five-stage RV32I pipeline.
//               Detects RAW dependencies of the ID instruction on EX/MEM/WB,
//               sequences multi-cycle stalls with a small FSM + counter, and
//               flushes the front end on a taken branch/jump resolved in EX.
// Config      : HAZARD_FWD_EN defined   -> forwarding active, only load-use
//                                           stalls (1 cycle).
//               HAZARD_FWD_EN undefined -> no forwarding; EX match stalls 2
//                                           cycles, MEM match stalls 1 cycle.
// Ports       : clk, rst                      - clock, sync active-high reset
//               Rs1/Rs2_addr_ID, _used_ID     - ID source registers
//               Rd_addr_*, RegWrite_*         - EX/MEM/WB destinations
//               MemtoReg_EX                   - 2'b01 marks a load in EX
//               Branch_taken_EX               - redirect resolved in EX
//               PC_EN_IF, IF_ID_EN            - front-end enables
//               IF_ID_flush, ID_EX_flush      - NOP / bubble insertion
//               Fwd_A_EX, Fwd_B_EX            - registered EX operand selects
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int STALL_CW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_addr_ID,
  input  logic [REG_AW-1:0] Rs2_addr_ID,
  input  logic              Rs1_used_ID,
  input  logic              Rs2_used_ID,
  input  logic [REG_AW-1:0] Rd_addr_EX,
  input  logic [REG_AW-1:0] Rd_addr_MEM,
  input  logic [REG_AW-1:0] Rd_addr_WB,
  input  logic              RegWrite_EX,
  input  logic              RegWrite_MEM,
  input  logic              RegWrite_WB,
  input  logic [1:0]        MemtoReg_EX,
  input  logic              Branch_taken_EX,
  output logic              PC_EN_IF,
  output logic              IF_ID_EN,
  output logic              IF_ID_flush,
  output logic              ID_EX_flush,
  output logic [1:0]        Fwd_A_EX,
  output logic [1:0]        Fwd_B_EX
);

  // --------------------------------------------------------------------------
  // Dependency matching: index 0 = EX, 1 = MEM, 2 = WB
  // --------------------------------------------------------------------------
  logic [REG_AW-1:0] stage_rd [3];
  logic [2:0]        stage_we;
  logic [2:0]        match_rs1;
  logic [2:0]        match_rs2;

  assign stage_rd[0] = Rd_addr_EX;
  assign stage_rd[1] = Rd_addr_MEM;
  assign stage_rd[2] = Rd_addr_WB;
  assign stage_we    = {RegWrite_WB, RegWrite_MEM, RegWrite_EX};

  generate
    for (genvar s = 0; s < 3; s++) begin : g_stage
      hazard_match #(.REG_AW(REG_AW)) u_match_rs1 (
        .rs_addr   (Rs1_addr_ID),
        .rs_used   (Rs1_used_ID),
        .rd_addr   (stage_rd[s]),
        .reg_write (stage_we[s]),
        .match     (match_rs1[s])
      );
      hazard_match #(.REG_AW(REG_AW)) u_match_rs2 (
        .rs_addr   (Rs2_addr_ID),
        .rs_used   (Rs2_used_ID),
        .rd_addr   (stage_rd[s]),
        .reg_write (stage_we[s]),
        .match     (match_rs2[s])
      );
    end
  endgenerate

  // The register file bypasses same-cycle WB writes to its read ports, so a
  // WB match needs neither a stall nor a forward.
  logic unused_wb_match;
  assign unused_wb_match = ^{match_rs1[2], match_rs2[2]};

  // --------------------------------------------------------------------------
  // Required stall length and next forwarding selects
  // --------------------------------------------------------------------------
  logic [STALL_CW-1:0] need_cnt;
  logic [1:0]          fwd_a_next;
  logic [1:0]          fwd_b_next;

`ifdef HAZARD_FWD_EN
  logic load_in_ex;
  assign load_in_ex = (MemtoReg_EX == MEMTOREG_LOAD);

  // Selects are computed one stage early: a producer now in EX sits in MEM
  // when the consumer reaches EX (forward its ALU result), and a producer
  // now in MEM sits in WB by then (forward the write-back data). A load in
  // EX has no ALU result to forward, hence the one-cycle load-use stall.
  always_comb begin
    need_cnt   = '0;
    fwd_a_next = FWD_REG;
    fwd_b_next = FWD_REG;
    if (load_in_ex && (match_rs1[0] || match_rs2[0]))
      need_cnt = STALL_CW'(1);
    if (match_rs1[0])      fwd_a_next = FWD_MEM;
    else if (match_rs1[1]) fwd_a_next = FWD_WB;
    if (match_rs2[0])      fwd_b_next = FWD_MEM;
    else if (match_rs2[1]) fwd_b_next = FWD_WB;
  end
`else
  logic [STALL_CW-1:0] need_a;
  logic [STALL_CW-1:0] need_b;
  logic [1:0]          unused_memtoreg;
  assign unused_memtoreg = MemtoReg_EX;

  // Without forwarding the consumer waits until the producer reaches WB.
  always_comb begin
    need_a     = match_rs1[0] ? STALL_CW'(2) : (match_rs1[1] ? STALL_CW'(1) : '0);
    need_b     = match_rs2[0] ? STALL_CW'(2) : (match_rs2[1] ? STALL_CW'(1) : '0);
    need_cnt   = (need_a > need_b) ? need_a : need_b;
    fwd_a_next = FWD_REG;
    fwd_b_next = FWD_REG;
  end
`endif

  // --------------------------------------------------------------------------
  // Stall FSM
  // --------------------------------------------------------------------------
  state_t              state;
  logic [STALL_CW-1:0] stall_cnt;
  logic                hazard;

  assign hazard = (need_cnt != '0);

  // Combinational front-end control; branch redirect overrides any stall
  // because the ID instruction is on the wrong path.
  always_comb begin
    PC_EN_IF    = 1'b1;
    IF_ID_EN    = 1'b1;
    IF_ID_flush = 1'b0;
    ID_EX_flush = 1'b0;
    if (rst) begin
      PC_EN_IF    = 1'b1;
    end else if (Branch_taken_EX) begin
      IF_ID_flush = 1'b1;
      ID_EX_flush = 1'b1;
    end else if ((state == STALL) || hazard) begin
      PC_EN_IF    = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_EX_flush = 1'b1;
    end
  end

  // stall_cnt holds the number of STALL-state cycles still to come,
  // including the current one; the last one returns the FSM to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      Fwd_A_EX  <= FWD_REG;
      Fwd_B_EX  <= FWD_REG;
    end else begin
      // A bubble entering EX must not forward anything.
      Fwd_A_EX <= ID_EX_flush ? FWD_REG : fwd_a_next;
      Fwd_B_EX <= ID_EX_flush ? FWD_REG : fwd_b_next;

      if (Branch_taken_EX) begin
        state     <= RUN;
        stall_cnt <= '0;
      end else if (state == STALL) begin
        if (stall_cnt <= STALL_CW'(1)) begin
          state     <= RUN;
          stall_cnt <= '0;
        end else begin
          stall_cnt <= stall_cnt - STALL_CW'(1);
        end
      end else if (hazard) begin
        stall_cnt <= need_cnt - STALL_CW'(1);
        state     <= (need_cnt > STALL_CW'(1)) ? STALL : RUN;
      end
    end
  end

endmodule : pipeline_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed scoreboard bench for pipeline_hazard_ctrl. Each
//               stimulus cycle pushes its hand-computed expectation (front-end
//               controls and registered forwarding selects) into a queue; a
//               monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // {PC_EN_IF, IF_ID_EN, IF_ID_flush, ID_EX_flush}
  localparam logic [3:0] RUNC = 4'b1100;
  localparam logic [3:0] STLC = 4'b0001;
  localparam logic [3:0] FLSC = 4'b1111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rde = '0, rdm = '0, rdw = '0;
  logic       u1 = 1'b0, u2 = 1'b0, we = 1'b0, wm = 1'b0, ww = 1'b0, br = 1'b0;
  logic [1:0] m2r = '0;
  logic       pc_en, ifid_en, ifid_fl, idex_fl;
  logic [1:0] fa, fb;

  typedef struct {
    string      nm;
    logic [3:0] ctl;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 1'b0;

  pipeline_hazard_ctrl #(.REG_AW(5), .STALL_CW(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .Rs1_addr_ID     (rs1),
    .Rs2_addr_ID     (rs2),
    .Rs1_used_ID     (u1),
    .Rs2_used_ID     (u2),
    .Rd_addr_EX      (rde),
    .Rd_addr_MEM     (rdm),
    .Rd_addr_WB      (rdw),
    .RegWrite_EX     (we),
    .RegWrite_MEM    (wm),
    .RegWrite_WB     (ww),
    .MemtoReg_EX     (m2r),
    .Branch_taken_EX (br),
    .PC_EN_IF        (pc_en),
    .IF_ID_EN        (ifid_en),
    .IF_ID_flush     (ifid_fl),
    .ID_EX_flush     (idex_fl),
    .Fwd_A_EX        (fa),
    .Fwd_B_EX        (fb)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and record what the
  // DUT must show during that cycle.
  task automatic step(input string nm, input logic r,
                      input logic [4:0] a1, input logic [4:0] a2,
                      input logic v1, input logic v2,
                      input logic [4:0] e_rd, input logic e_we, input logic [1:0] e_m2r,
                      input logic [4:0] m_rd, input logic m_we,
                      input logic [4:0] w_rd, input logic w_we,
                      input logic b, input logic [3:0] ctl,
                      input logic [1:0] efa, input logic [1:0] efb);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; rs1 = a1; rs2 = a2; u1 = v1; u2 = v2;
    rde = e_rd; we = e_we; m2r = e_m2r; rdm = m_rd; wm = m_we;
    rdw = w_rd; ww = w_we; br = b;
    e.nm = nm; e.ctl = ctl; e.fa = efa; e.fb = efb;
    exp_q.push_back(e);
  endtask

  // No dependencies anywhere.
  task automatic idle(input string nm, input logic [3:0] ctl,
                      input logic [1:0] efa, input logic [1:0] efb);
    step(nm, 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 2'b00,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b0, ctl, efa, efb);
  endtask

  // Monitor: compare whenever an expectation is pending.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        logic [7:0] act, req;
        e   = exp_q.pop_front();
        act = {pc_en, ifid_en, ifid_fl, idex_fl, fa, fb};
        req = {e.ctl, e.fa, e.fb};
        checks++;
        if (act !== req) begin
          failures++;
          $display("FAIL %s: got ctl=%b fa=%b fb=%b expected ctl=%b fa=%b fb=%b",
                   e.nm, act[7:4], act[3:2], act[1:0], req[7:4], req[3:2], req[1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Reset with a hazard present: enables stay high, no flush.
    step("reset",      1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b0, RUNC, 2'b00, 2'b00);
    idle("rst_hold_rel", RUNC, 2'b00, 2'b00);

    // lw x5 in EX, add x6,x5,x7 in ID
    step("loaduse",    1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd5, 1'b1, 2'b01,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b0, STLC, 2'b00, 2'b00);
    step("loaduse_c2", 1'b0, 5'd5, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 2'b00,
         5'd5, 1'b1, 5'd0, 1'b0, 1'b0, FWD ? RUNC : STLC, 2'b00, 2'b00);
    step("loaduse_fwd", 1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 2'b00,
         5'd0, 1'b0, 5'd5, 1'b1, 1'b0, RUNC, FWD ? 2'b10 : 2'b00, 2'b00);

    // add x5 in EX, sub x8,x1,x5 in ID
    step("raw_ex",     1'b0, 5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00,
         5'd6, 1'b1, 5'd0, 1'b0, 1'b0, FWD ? RUNC : STLC, 2'b00, 2'b00);
    step("raw_ex_c2",  1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b1, 2'b00,
         5'd5, 1'b1, 5'd0, 1'b0, 1'b0, FWD ? RUNC : STLC, 2'b00, FWD ? 2'b01 : 2'b00);
    step("raw_ex_end", 1'b0, 5'd9, 5'd10, 1'b1, 1'b1, 5'd3, 1'b1, 2'b00,
         5'd8, 1'b1, 5'd5, 1'b1, 1'b0, RUNC, 2'b00, 2'b00);

    // x0 destinations never create a dependency
    step("x0",         1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 2'b01,
         5'd0, 1'b1, 5'd0, 1'b1, 1'b0, RUNC, 2'b00, 2'b00);
    idle("x0_fwd", RUNC, 2'b00, 2'b00);

    // Branch during a stall (cycle 1 of 2 without forwarding)
    step("br_setup",   1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b0, STLC, 2'b00, 2'b00);
    step("br_in_stall", 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FLSC, 2'b00, 2'b00);
    idle("br_after", RUNC, 2'b00, 2'b00);

    // Branch and hazard together: flush only
    step("br_haz",     1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b1, FLSC, 2'b00, 2'b00);
    idle("br_haz_after", RUNC, 2'b00, 2'b00);

    // Reset in the middle of a stall
    step("rst_setup",  1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b0, STLC, 2'b00, 2'b00);
    step("rst_mid",    1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 2'b01,
         5'd0, 1'b0, 5'd0, 1'b0, 1'b0, RUNC, 2'b00, 2'b00);
    idle("rst_after", RUNC, 2'b00, 2'b00);

    // WB match never stalls
    step("wb_match",   1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 2'b00,
         5'd0, 1'b0, 5'd5, 1'b1, 1'b0, RUNC, 2'b00, 2'b00);
    // MEM match: 1-cycle stall without forwarding, WB forward with it
    step("mem_match",  1'b0, 5'd0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 2'b00,
         5'd6, 1'b1, 5'd0, 1'b0, 1'b0, FWD ? RUNC : STLC, 2'b00, 2'b00);
    idle("mem_after", RUNC, 2'b00, FWD ? 2'b10 : 2'b00);

    // rs1 on EX, rs2 on MEM: the longer stall wins
    step("dual",       1'b0, 5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 2'b00,
         5'd6, 1'b1, 5'd0, 1'b0, 1'b0, FWD ? RUNC : STLC, 2'b00, 2'b00);
    idle("dual_c2", FWD ? RUNC : STLC, FWD ? 2'b01 : 2'b00, FWD ? 2'b10 : 2'b00);
    idle("dual_end", RUNC, 2'b00, 2'b00);

    stim_done = 1'b1;
  end

  // Completion with a bounded drain of the scoreboard.
  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 1000) begin
      @(posedge clk);
      budget++;
    end
    repeat (2) @(posedge clk);
    if (!stim_done || exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got pending=%0d done=%0d expected pending=0 done=1",
               exp_q.size(), stim_done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
`default_nettype wire
